// File: rtl/rn_sam_pipe.sv
// RN-side system address map: a 2-entry registered buffer that stamps each flit with its home slice tgt_id and src_id.
// Defining RN_SAM_PERF_CNT_EN adds one saturating 16-bit pop counter per slice.
package rn_sam_pipe_pkg;
  localparam int unsigned NodeID_X_Width = 2;
  localparam int unsigned NodeID_Y_Width = 2;
  localparam int unsigned FlitAddrW      = 40;
  localparam int unsigned IoPortW        = 5;
  localparam int unsigned FlitRsvdW      = 256 - 4 - FlitAddrW - 12 - 2 * 7;

  typedef logic [IoPortW-1:0] io_port_t;

  typedef struct packed {
    logic [1:0]                device_id;
    logic                      device_port;
    logic [NodeID_Y_Width-1:0] y;
    logic [NodeID_X_Width-1:0] x;
  } node_id_t;

  typedef struct packed {
    logic [7:0] txn;
    logic [3:0] sid;
  } flit_id_t;

  typedef struct packed {
    logic [FlitRsvdW-1:0] rsvd;
    logic [3:0]           qos_value;
    logic [FlitAddrW-1:0] addr;
    flit_id_t             id;
    node_id_t             tgt_id;
    node_id_t             src_id;
  } flit_payload_t;

  typedef struct packed {
    logic [3:0] qos_value;
    node_id_t   tgt_id;
    node_id_t   src_id;
    io_port_t   look_ahead_routing;
  } flit_dec_t;

  typedef struct packed {
    flit_payload_t flit;
    io_port_t      lar;
  } sam_entry_t;
endpackage

module rn_sam_pipe
  import rn_sam_pipe_pkg::*;
#(
  parameter bit          SLICED_LLC    = 1'b1,
  parameter bit          HAS_ADDR      = 1'b1,
  parameter bit          USE_QOS_VALUE = 1'b1,
  parameter int unsigned LLC_SLICE_NUM = 9,
  parameter int unsigned NODE_NUM_X    = 3,
  parameter int unsigned HN_X          = 1,
  parameter int unsigned HN_Y          = 0,
  parameter int unsigned ADDR_W        = 40
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NodeID_X_Width-1:0]     node_id_x_i,
  input  logic [NodeID_Y_Width-1:0]     node_id_y_i,
  input  logic [2:0]                    cfg_intlv_sel_i,
  input  logic [4:0]                    cfg_slice_num_i,
  output logic                          cfg_busy_o,
  input  logic                          flit_v_i,
  output logic                          flit_rdy_o,
  input  flit_payload_t                 flit_i,
  input  io_port_t                      flit_look_ahead_routing_i,
  output logic                          flit_v_o,
  input  logic                          flit_rdy_i,
  output flit_payload_t                 flit_o,
  output flit_dec_t                     flit_dec_o,
  output logic [LLC_SLICE_NUM*16-1:0]   perf_cnt_o
);

  localparam int unsigned FieldW = (LLC_SLICE_NUM > 1) ? $clog2(LLC_SLICE_NUM) : 1;
  localparam int unsigned SliceW = FieldW;
  localparam logic [4:0]  SnMax  = 5'(LLC_SLICE_NUM);

  logic              push, pop, load;
  logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              v_q, v_d, rdy_q, rdy_d, busy_q, busy_d;
  logic [2:0]        sel_q, sel_d;
  logic [4:0]        sn_q, sn_d, sn_in;
  logic [ADDR_W-1:0] addr;
  logic [8:0]        rem;
  logic [SliceW-1:0] slice;
  node_id_t          tgt, src;
  sam_entry_t        entry_w;
  sam_entry_t        mem_q [2];

  assign push = flit_v_i & rdy_q;
  assign pop  = v_q & flit_rdy_i;

  // Out-of-range slice counts fall back to the full slice set.
  assign sn_in = (cfg_slice_num_i == 5'd0 || cfg_slice_num_i > SnMax) ? SnMax : cfg_slice_num_i;

  // Buffer bookkeeping and shadow cfg: the shadow only reloads while the buffer is idle.
  always_comb begin
    cnt_d    = cnt_q + 2'(push) - 2'(pop);
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    load     = busy_q && (cnt_q == 2'd0) && !push;
    sel_d    = load ? cfg_intlv_sel_i : sel_q;
    sn_d     = load ? sn_in : sn_q;
    busy_d   = (sel_d != cfg_intlv_sel_i) || (sn_d != sn_in);
    v_d      = (cnt_d != 2'd0);
    rdy_d    = (cnt_d != 2'd2) && !(busy_d && (cnt_d == 2'd0));
  end

  // Slice decode at push; modulo by restoring compare-subtract.
  always_comb begin
    addr = ADDR_W'(flit_i.addr);
    if (HAS_ADDR) rem = 9'(FieldW'(addr >> (6 + 32'(sel_q))));
    else          rem = 9'(flit_i.id.sid);
    for (int k = 3; k >= 0; k--) begin
      if (rem >= (9'(sn_q) << k)) rem = rem - (9'(sn_q) << k);
    end
    slice = SliceW'(rem);

    tgt = '0;
    if (SLICED_LLC) begin
      tgt.x           = NodeID_X_Width'(32'(slice) % NODE_NUM_X);
      tgt.y           = NodeID_Y_Width'(32'(slice) / NODE_NUM_X);
      tgt.device_port = 1'b1;
    end else begin
      tgt.x = NodeID_X_Width'(HN_X);
      tgt.y = NodeID_Y_Width'(HN_Y);
    end

    src   = '0;
    src.x = node_id_x_i;
    src.y = node_id_y_i;

    entry_w             = '{flit: flit_i, lar: flit_look_ahead_routing_i};
    entry_w.flit.tgt_id = tgt;
    entry_w.flit.src_id = src;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      v_q      <= 1'b0;
      rdy_q    <= 1'b1;
      busy_q   <= 1'b0;
      sel_q    <= 3'd0;
      sn_q     <= SnMax;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      v_q      <= v_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      sel_q    <= sel_d;
      sn_q     <= sn_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_w;
  end

  assign flit_v_o   = v_q;
  assign flit_rdy_o = rdy_q;
  assign cfg_busy_o = busy_q;
  assign flit_o     = mem_q[rd_ptr_q].flit;

  always_comb begin
    flit_dec_o                    = '0;
    flit_dec_o.qos_value          = USE_QOS_VALUE ? mem_q[rd_ptr_q].flit.qos_value : 4'd0;
    flit_dec_o.tgt_id             = mem_q[rd_ptr_q].flit.tgt_id;
    flit_dec_o.src_id             = mem_q[rd_ptr_q].flit.src_id;
    flit_dec_o.look_ahead_routing = mem_q[rd_ptr_q].lar;
  end

`ifdef RN_SAM_PERF_CNT_EN
  logic [SliceW-1:0] slice_mem_q [2];
  logic [15:0]       perf_q [LLC_SLICE_NUM];
  logic [15:0]       perf_d [LLC_SLICE_NUM];

  always_ff @(posedge clk) begin
    if (push) slice_mem_q[wr_ptr_q] <= slice;
  end

  // Saturating per-slice pop counters.
  always_comb begin
    perf_d = perf_q;
    for (int i = 0; i < int'(LLC_SLICE_NUM); i++) begin
      if (pop && slice_mem_q[rd_ptr_q] == SliceW'(i) && perf_q[i] != 16'hFFFF) begin
        perf_d[i] = perf_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < int'(LLC_SLICE_NUM); i++) perf_q[i] <= 16'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  for (genvar g = 0; g < int'(LLC_SLICE_NUM); g++) begin : g_perf
    assign perf_cnt_o[g*16 +: 16] = perf_q[g];
  end
`else
  assign perf_cnt_o = '0;
`endif

endmodule
